// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: formatter states, frame constants and nibble-to-ASCII helper shared by the debug UART streamer
package debug_uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_HEX, S_SEP, S_CR, S_LF} fmt_state_t;
  localparam int FRAME_BYTES = 37;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/dbg_uart_tx.sv
// dbg_uart_tx: 8N1 byte serializer with valid/ready byte input
//  clk, rst   clock, synchronous active-high reset
//  valid/data byte offered; taken on a cycle where valid and ready are both high
//  ready      high only while idle (including the final cycle of a stop bit)
//  txd        serial line, idle high
module dbg_uart_tx #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);
  logic       act;
  logic [8:0] sh;
  logic [3:0] bitn;
  logic [15:0] cnt;
  logic       last;
  // The stop bit's final cycle is spent idle with ready high, so a queued byte
  // starts right on the bit boundary and bytes run back to back.
  always_comb begin
    ready = !act;
    last = cnt == ((bitn == 4'd9) ? 16'(BAUD_DIV - 2) : 16'(BAUD_DIV - 1));
  end
  always_ff @(posedge clk)
    if (rst) begin
      act <= 1'b0;
      txd <= 1'b1;
      sh <= '0;
      bitn <= '0;
      cnt <= '0;
    end else if (!act) begin
      if (valid) begin
        act <= 1'b1;
        txd <= 1'b0;
        sh <= {1'b1, data};
        bitn <= '0;
        cnt <= '0;
      end
    end else if (last) begin
      cnt <= '0;
      bitn <= bitn + 4'd1;
      if (bitn == 4'd9) act <= 1'b0;
      else begin
        txd <= sh[0];
        sh <= {1'b1, sh[8:1]};
      end
    end else cnt <= cnt + 16'd1;
endmodule

// File: rtl/debug_uart_streamer.sv
// debug_uart_streamer: snapshots four soc debug words on a capture event and streams them as an ASCII hex line over UART
//  XCLK, XRES  clock, synchronous active-high reset
//  DEBUG       four debug words, DEBUG[0] sent first
//  LED, PHS    LED change is an event unless PHS==0; TRIG manual event pulse
//  UART_TXD    8N1 serial out; BUSY frame in progress; DROPS saturating lost-event count
module debug_uart_streamer
  import debug_uart_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int PERIOD   = 100000000
) (
  input  logic            XCLK,
  input  logic            XRES,
  input  logic [3:0][31:0] DEBUG,
  input  logic [3:0]      LED,
  input  logic [1:0]      PHS,
  input  logic            TRIG,
  output logic            UART_TXD,
  output logic            BUSY,
  output logic [7:0]      DROPS
);
  fmt_state_t state;
  logic [3:0][31:0] snap;
  logic [1:0] w;
  logic [2:0] n;
  logic fin;
  logic [3:0] led_q;
  logic [31:0] per_cnt;
  logic per_hit, ev, valid, ready, hs;
  logic [7:0] tx_byte;
  always_comb begin
    per_hit = PERIOD != 0 && per_cnt == 32'(PERIOD - 1);
    ev = TRIG || (LED != led_q && PHS != 2'b00) || per_hit;
    BUSY = state != S_IDLE;
    // LF stays a frame state after its byte is taken so BUSY covers its stop bit
    valid = state != S_IDLE && !(state == S_LF && fin);
    tx_byte = (state == S_SEP) ? ASCII_SP :
              (state == S_CR)  ? ASCII_CR :
              (state == S_LF)  ? ASCII_LF : hex_ascii(snap[w][{n, 2'b00} +: 4]);
    hs = valid && ready;
  end
  always_ff @(posedge XCLK)
    if (XRES) begin
      state <= S_IDLE;
      snap <= '0;
      w <= '0;
      n <= '0;
      fin <= 1'b0;
      led_q <= LED;
      per_cnt <= '0;
      DROPS <= '0;
    end else begin
      led_q <= LED;
      per_cnt <= (PERIOD == 0 || per_hit) ? '0 : per_cnt + 32'd1;
      if (ev && BUSY && DROPS != 8'hFF) DROPS <= DROPS + 8'd1;
      case (state)
        S_IDLE: if (ev) begin
          snap <= DEBUG;
          w <= '0;
          n <= 3'd7;
          state <= S_SNAP;
        end
        // SNAP offers the first hex character straight from the fresh snapshot
        S_SNAP: if (hs) begin
          n <= n - 3'd1;
          state <= S_HEX;
        end
        S_HEX: if (hs) begin
          n <= n - 3'd1;
          if (n == 3'd0) state <= (w == 2'd3) ? S_CR : S_SEP;
        end
        S_SEP: if (hs) begin
          w <= w + 2'd1;
          n <= 3'd7;
          state <= S_HEX;
        end
        S_CR: if (hs) state <= S_LF;
        S_LF: if (fin && ready) begin
          fin <= 1'b0;
          state <= S_IDLE;
        end else if (hs) fin <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  dbg_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(XCLK),
    .rst(XRES),
    .valid(valid),
    .data(tx_byte),
    .ready(ready),
    .txd(UART_TXD)
  );
endmodule

// File: tb/tb_debug_uart_streamer.sv
// tb_debug_uart_streamer: decodes the UART line mid-bit and scores it against expected ASCII frames
module tb_debug_uart_streamer;
  import debug_uart_pkg::*;
  localparam int BD = 4;
  localparam int FRAME_CYC = FRAME_BYTES * 10 * BD;
  typedef struct {
    logic [3:0][31:0] d;
    string s;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rst_p = 1'b1, trig = 1'b0, zero = 1'b0;
  logic [3:0][31:0] debug = '0;
  logic [3:0] led = '0, led_p = '0;
  logic [1:0] phs = 2'b01;
  logic txd, busy, txd_2k, busy_2k, txd_1k, busy_1k;
  logic [7:0] drops, drops_2k, drops_1k;
  int cyc = 0, checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  vec_t tv[4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  debug_uart_streamer #(.BAUD_DIV(BD), .PERIOD(0)) u_dut (
    .XCLK(clk), .XRES(rst), .DEBUG(debug), .LED(led), .PHS(phs), .TRIG(trig),
    .UART_TXD(txd), .BUSY(busy), .DROPS(drops));
  debug_uart_streamer #(.BAUD_DIV(BD), .PERIOD(2000)) u_p2k (
    .XCLK(clk), .XRES(rst_p), .DEBUG(debug), .LED(led_p), .PHS(2'b01), .TRIG(zero),
    .UART_TXD(txd_2k), .BUSY(busy_2k), .DROPS(drops_2k));
  debug_uart_streamer #(.BAUD_DIV(BD), .PERIOD(1000)) u_p1k (
    .XCLK(clk), .XRES(rst_p), .DEBUG(debug), .LED(led_p), .PHS(2'b01), .TRIG(zero),
    .UART_TXD(txd_1k), .BUSY(busy_1k), .DROPS(drops_1k));
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic pulse_trig(output int tc);
    @(posedge clk);
    #1 trig = 1'b1;
    tc = cyc;
    @(posedge clk);
    #1 trig = 1'b0;
  endtask
  task automatic push_frame(input int v);
    string s;
    s = tv[v].s;
    debug = tv[v].d;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask
  task automatic recv_byte(input int lim, output logic [7:0] b, output int t, output bit ok);
    ok = 1'b0;
    b = '0;
    t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t = cyc;
    repeat (BD / 2) @(negedge clk);
    chk("start bit at mid-bit", txd, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (BD) @(negedge clk);
      b[k] = txd;
    end
    repeat (BD) @(negedge clk);
    chk("stop bit at mid-bit", txd, 1);
  endtask
  task automatic recv_frame(input int lim, output int t0);
    logic [7:0] b;
    int t, tp;
    bit ok, gap_ok;
    gap_ok = 1'b1;
    t0 = 0;
    tp = 0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      recv_byte((i == 0) ? lim : BD + 1, b, t, ok);
      chk("rx start bit found", ok, 1);
      if (!ok) return;
      if (i == 0) t0 = t;
      else if (t != tp + 10 * BD) gap_ok = 1'b0;
      tp = t;
      if (exp_q.size() == 0) chk("rx byte with empty scoreboard", exp_q.size(), 1);
      else chk("rx byte", b, exp_q.pop_front());
    end
    chk("bytes back to back", gap_ok, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
    chk("busy clears", busy, 0);
  endtask
  task automatic quiet(input int ncy, input string name);
    bit act;
    act = 1'b0;
    repeat (ncy) begin
      @(negedge clk);
      if (!txd || busy) act = 1'b1;
    end
    chk(name, act, 0);
  endtask
  initial begin
    int tc, t0, t1, tb;
    int r2[$], r1[$], d1[$];
    logic pb2, pb1;
    tv[0].d = {32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF, 32'h12345678};
    tv[0].s = "12345678 DEADBEEF 00000000 FFFFFFFF\r\n";
    tv[1].d = {32'h0F1E2D3C, 32'hA5A5A5A5, 32'h89ABCDEF, 32'h01234567};
    tv[1].s = "01234567 89ABCDEF A5A5A5A5 0F1E2D3C\r\n";
    tv[2].d = {32'h80000001, 32'h0000FFFF, 32'h9999AAAA, 32'hCAFEF00D};
    tv[2].s = "CAFEF00D 9999AAAA 0000FFFF 80000001\r\n";
    tv[3].d = {32'h0A0B0C0D, 32'h3C3C3C3C, 32'h76543210, 32'hFEDCBA98};
    tv[3].s = "FEDCBA98 76543210 3C3C3C3C 0A0B0C0D\r\n";
    repeat (3) @(posedge clk);
    #1;
    chk("reset txd", txd, 1);
    chk("reset busy", busy, 0);
    chk("reset drops", drops, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    quiet(10, "idle after reset release");
    // table: every vector triggered, decoded and timed; DEBUG scrambled after the snapshot
    for (int v = 0; v < 4; v++) begin
      push_frame(v);
      pulse_trig(tc);
      chk("busy from snapshot", busy, 1);
      debug = ~tv[v].d;
      recv_frame(20, t0);
      chk("start bit latency after trig", t0 - tc, 2);
      while (cyc < t0 + FRAME_CYC - 1) @(negedge clk);
      chk("busy through last stop bit", busy, 1);
      chk("txd high in last stop bit", txd, 1);
      @(negedge clk);
      chk("busy falls after frame", busy, 0);
      repeat (5) @(posedge clk);
    end
    // LED change with PHS active starts a frame; with PHS==0 it is ignored
    push_frame(1);
    @(posedge clk);
    #1 led = 4'd1;
    tc = cyc;
    recv_frame(20, t0);
    chk("led event start latency", t0 - tc, 2);
    wait_idle();
    phs = 2'b00;
    @(posedge clk);
    #1 led = 4'd2;
    quiet(60, "no frame for led change in reset phase");
    chk("drops after masked led change", drops, 0);
    phs = 2'b01;
    quiet(20, "no frame after phase release");
    // triggers during a frame are dropped; a simultaneous trig+led counts once
    push_frame(2);
    pulse_trig(tc);
    fork
      recv_frame(20, t0);
      begin
        repeat (100) @(posedge clk);
        pulse_trig(t1);
        repeat (100) @(posedge clk);
        pulse_trig(t1);
        repeat (100) @(posedge clk);
        #1 trig = 1'b1;
        led = 4'd3;
        @(posedge clk);
        #1 trig = 1'b0;
      end
    join
    chk("drops after three events", drops, 3);
    wait_idle();
    quiet(60, "no frame for dropped events");
    push_frame(3);
    pulse_trig(tc);
    fork
      recv_frame(20, t0);
      repeat (300) pulse_trig(t1);
    join
    chk("drops saturate", drops, 255);
    wait_idle();
    chk("drops hold at saturation", drops, 255);
    // reset mid-byte aborts the frame
    debug = tv[0].d;
    pulse_trig(tc);
    for (int i = 0; i < 20 && txd; i++) @(negedge clk);
    chk("frame starts before reset", txd, 0);
    t0 = cyc;
    while (cyc < t0 + 10 * BD + 1) @(negedge clk);
    chk("txd in start bit of second byte", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("txd after mid-frame reset", txd, 1);
    chk("busy after mid-frame reset", busy, 0);
    chk("drops after mid-frame reset", drops, 0);
    rst = 1'b0;
    quiet(30, "idle after mid-frame reset");
    push_frame(1);
    pulse_trig(tc);
    recv_frame(20, t0);
    chk("start latency after reset", t0 - tc, 2);
    wait_idle();
    // trigger in the first cycle BUSY is low is accepted
    push_frame(2);
    pulse_trig(tc);
    fork
      begin
        recv_frame(20, t0);
        recv_frame(20, tb);
      end
      begin
        for (int i = 0; i < 3000 && busy; i++) begin
          @(posedge clk);
          #1;
        end
        chk("busy fell before second trigger", busy, 0);
        push_frame(3);
        trig = 1'b1;
        t1 = cyc;
        @(posedge clk);
        #1 trig = 1'b0;
      end
    join
    chk("second frame start latency", tb - t1, 2);
    chk("second frame spacing", tb - t0, FRAME_CYC + 2);
    chk("drops after boundary trigger", drops, 0);
    wait_idle();
    // periodic capture
    @(posedge clk);
    #1 rst_p = 1'b0;
    pb2 = busy_2k;
    pb1 = busy_1k;
    for (int i = 0; i < 8200; i++) begin
      @(negedge clk);
      if (busy_2k && !pb2) r2.push_back(cyc);
      if (busy_1k && !pb1) begin
        r1.push_back(cyc);
        d1.push_back(int'(drops_1k));
      end
      pb2 = busy_2k;
      pb1 = busy_1k;
    end
    chk("period 2000 frame count", r2.size(), 4);
    chk("period 1000 frame count", r1.size(), 4);
    for (int k = 1; k < r2.size(); k++) chk("period 2000 interval", r2[k] - r2[k-1], 2000);
    for (int k = 1; k < r1.size(); k++) chk("period 1000 interval", r1[k] - r1[k-1], 2000);
    for (int k = 0; k < d1.size(); k++) chk("period 1000 drops at frame start", d1[k], k);
    chk("period 2000 drops", drops_2k, 0);
    chk("period 1000 drops at end", drops_1k, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
